// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receiver FSM states, acknowledge levels, default byte size.
package i2c_pkg;

  localparam int unsigned I2C_SIZE_DEFAULT = 8;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECV      = 2'd1,
    BYTE_DONE = 2'd2
  } i2c_state_e;

endpackage

// File: rtl/i2c_byte_receiver_if.sv
// Bus-side and consumer-side signals of the I2C byte receiver.
interface i2c_byte_receiver_if
  import i2c_pkg::*;
#(
  parameter int unsigned SIZE = I2C_SIZE_DEFAULT
);

  logic            scl;
  logic            sda;
  logic            rx_ready;
  logic [SIZE-1:0] rx_data;
  logic            rx_valid;
  logic            rx_ack;
  logic            busy;
  logic            stop_seen;
  logic            frame_err;
  logic            overrun;

  // Line driver plus byte consumer.
  modport master (
    output scl, sda, rx_ready,
    input  rx_data, rx_valid, rx_ack, busy, stop_seen, frame_err, overrun
  );

  // The byte receiver itself.
  modport slave (
    input  scl, sda, rx_ready,
    output rx_data, rx_valid, rx_ack, busy, stop_seen, frame_err, overrun
  );

endinterface

// File: rtl/i2c_line_sync.sv
// SDA/SCL synchronisers with SCL edge and START/STOP condition detection.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s_o,
  output logic scl_rise_c_o,
  output logic scl_fall_c_o,
  output logic start_c_o,
  output logic stop_c_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_p_q;
  logic                   sda_p_q;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  // Synchroniser chains and previous-sample registers, preset to the idle bus level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      scl_p_q <= scl_s;
      sda_p_q <= sda_s;
    end
  end

  // START/STOP need SCL steady high, so an SDA change alongside an SCL edge never qualifies.
  assign sda_s_o      = sda_s;
  assign scl_rise_c_o = !scl_p_q && scl_s;
  assign scl_fall_c_o = scl_p_q && !scl_s;
  assign start_c_o    = scl_p_q && scl_s && sda_p_q && !sda_s;
  assign stop_c_o     = scl_p_q && scl_s && !sda_p_q && sda_s;

endmodule

// File: rtl/i2c_byte_receiver.sv
// I2C byte receiver: decodes START/STOP, shifts bytes LSB-first, holds them for a valid/ready consumer.
module i2c_byte_receiver
  import i2c_pkg::*;
#(
  parameter int unsigned SIZE        = I2C_SIZE_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                clk,
  input logic                reset,
  i2c_byte_receiver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(SIZE + 1);

  logic            sda_s;
  logic            scl_rise;
  logic            scl_fall;
  logic            start_cond;
  logic            stop_cond;
  logic            unused_fall;

  i2c_state_e      state_q,     state_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [SIZE-1:0] shift_q,     shift_d;
  logic [SIZE-1:0] rx_data_q,   rx_data_d;
  logic            rx_valid_q,  rx_valid_d;
  logic            rx_ack_q,    rx_ack_d;
  logic            busy_q,      busy_d;
  logic            stop_seen_q, stop_seen_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q,   overrun_d;
  logic            byte_done;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk          (clk),
    .reset        (reset),
    .scl_i        (bus.scl),
    .sda_i        (bus.sda),
    .sda_s_o      (sda_s),
    .scl_rise_c_o (scl_rise),
    .scl_fall_c_o (scl_fall),
    .start_c_o    (start_cond),
    .stop_c_o     (stop_cond)
  );

  // Data is sampled on SCL rise only; the falling edge has no role here.
  assign unused_fall = scl_fall;

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ack_q    <= I2C_NACK;
      busy_q      <= 1'b0;
      stop_seen_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ack_q    <= rx_ack_d;
      busy_q      <= busy_d;
      stop_seen_q <= stop_seen_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state, shift, holding-register and flag logic.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_ack_d    = rx_ack_q;
    stop_seen_d = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    if (rx_valid_q && bus.rx_ready) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start_cond) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end else if (stop_cond) begin
          stop_seen_d = 1'b1;
        end
      end
      RECV: begin
        if (stop_cond) begin
          frame_err_d = 1'b1;
          stop_seen_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = IDLE;
        end else if (start_cond) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
        end else if (scl_rise) begin
          if (bit_cnt_q < CNT_W'(SIZE)) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
              if (bit_cnt_q == CNT_W'(i)) begin
                shift_d[i] = sda_s;
              end
            end
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
            byte_done = 1'b1;
            bit_cnt_d = '0;
            state_d   = BYTE_DONE;
          end
        end
      end
      BYTE_DONE: begin
        if (stop_cond) begin
          stop_seen_d = 1'b1;
          state_d     = IDLE;
        end else if (start_cond) begin
          bit_cnt_d = '0;
          state_d   = RECV;
        end else if (scl_rise) begin
          shift_d[0] = sda_s;
          bit_cnt_d  = CNT_W'(1);
          state_d    = RECV;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // A finished byte loads only if the holding register is free or being emptied now.
    if (byte_done) begin
      if (!rx_valid_q || bus.rx_ready) begin
        rx_data_d  = shift_q;
        rx_ack_d   = sda_s;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_ack    = rx_ack_q;
  assign bus.busy      = busy_q;
  assign bus.stop_seen = stop_seen_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_i2c_byte_receiver.sv
// Self-checking bench for i2c_byte_receiver: transaction-level model plus per-cycle compare.
module tb_i2c_byte_receiver;
  import i2c_pkg::*;

  localparam int unsigned SIZE = I2C_SIZE_DEFAULT;
  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  i2c_byte_receiver_if #(.SIZE(SIZE)) bus ();

  i2c_byte_receiver #(
    .SIZE        (SIZE),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit            complete;
    bit [SIZE-1:0] data;
    bit            ack;
    bit            stop;
    bit            ferr;
    bit            busy;
  } ev_t;

  ev_t pipe[$];
  bit  m_active = 0;
  bit  m_after  = 0;
  bit  m_bits[$];
  bit  p_scl = 1, p_sda = 1;

  bit [SIZE-1:0] e_data = '0;
  bit e_valid = 0, e_ack = 1, e_busy = 0, e_stop = 0, e_ferr = 0, e_ovr = 0;

  function automatic ev_t mk_null();
    ev_t e;
    e.complete = 0; e.data = '0; e.ack = 0; e.stop = 0; e.ferr = 0; e.busy = 0;
    return e;
  endfunction

  // Decode the raw lines as a bus observer would, then delay the effect by the synchroniser depth.
  always @(posedge clk or posedge reset) begin
    ev_t ev;
    ev_t d;
    bit  scl, sda, rise, st, sp;
    if (reset) begin
      m_active = 0; m_after = 0; m_bits.delete();
      p_scl = 1; p_sda = 1; pipe.delete();
      e_data = '0; e_valid = 0; e_ack = 1; e_busy = 0;
      e_stop = 0; e_ferr = 0; e_ovr = 0;
    end else begin
      ev   = mk_null();
      scl  = bus.scl;
      sda  = bus.sda;
      rise = !p_scl && scl;
      st   = p_scl && scl && p_sda && !sda;
      sp   = p_scl && scl && !p_sda && sda;
      if (sp) begin
        ev.stop  = 1;
        ev.ferr  = m_active && !m_after;
        m_active = 0; m_after = 0; m_bits.delete();
      end else if (st) begin
        ev.ferr  = m_active && !m_after;
        m_active = 1; m_after = 0; m_bits.delete();
      end else if (rise && m_active) begin
        m_after = 0;
        m_bits.push_back(sda);
        if (m_bits.size() == SIZE + 1) begin
          ev.complete = 1;
          for (int i = 0; i < SIZE; i++) ev.data[i] = m_bits[i];
          ev.ack = m_bits[SIZE];
          m_bits.delete();
          m_after = 1;
        end
      end
      ev.busy = m_active;
      p_scl = scl; p_sda = sda;
      pipe.push_back(ev);
      if (pipe.size() > SYNC) d = pipe.pop_front();
      else                    d = mk_null();
      e_stop = d.stop; e_ferr = d.ferr; e_busy = d.busy; e_ovr = 0;
      if (d.complete) begin
        if (!e_valid || bus.rx_ready) begin
          e_data = d.data; e_ack = d.ack; e_valid = 1;
        end else begin
          e_ovr = 1;
        end
      end else if (e_valid && bus.rx_ready) begin
        e_valid = 0;
      end
    end
  end

  // ---------------- per-cycle compare and event counters ----------------
  int n_vrise = 0, n_vcyc = 0, n_stop = 0, n_ferr = 0, n_ovr = 0, n_both = 0;
  logic [SIZE-1:0] caps[$];
  bit prev_valid = 0;

  always @(negedge clk) begin
    chk("rx_data",   32'(bus.rx_data),   32'(e_data));
    chk("rx_valid",  32'(bus.rx_valid),  32'(e_valid));
    chk("rx_ack",    32'(bus.rx_ack),    32'(e_ack));
    chk("busy",      32'(bus.busy),      32'(e_busy));
    chk("stop_seen", 32'(bus.stop_seen), 32'(e_stop));
    chk("frame_err", 32'(bus.frame_err), 32'(e_ferr));
    chk("overrun",   32'(bus.overrun),   32'(e_ovr));
    if (bus.rx_valid === 1'b1 && !prev_valid) begin
      n_vrise++;
      caps.push_back(bus.rx_data);
    end
    prev_valid = (bus.rx_valid === 1'b1);
    if (bus.rx_valid === 1'b1)  n_vcyc++;
    if (bus.stop_seen === 1'b1) n_stop++;
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.overrun === 1'b1)   n_ovr++;
    if (bus.stop_seen === 1'b1 && bus.frame_err === 1'b1) n_both++;
  end

  // ---------------- master line driver ----------------
  int h = 4;
  bit rr_en = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #2;
    if (rr_en) bus.rx_ready = 1'($urandom_range(0, 1));
  end

  task automatic start_c();
    bus.sda = 1'b0; cyc(h);
  endtask

  task automatic send_bit(input bit b);
    bus.scl = 1'b0; bus.sda = b; cyc(h);
    bus.scl = 1'b1; cyc(h);
  endtask

  task automatic send_byte(input logic [SIZE-1:0] v, input bit ack);
    for (int i = 0; i < SIZE; i++) send_bit(v[i]);
    send_bit(ack);
  endtask

  task automatic stop_c();
    if (bus.scl && !bus.sda) begin
      bus.sda = 1'b1;
    end else begin
      bus.scl = 1'b0; bus.sda = 1'b0; cyc(h);
      bus.scl = 1'b1; cyc(h);
      bus.sda = 1'b1;
    end
    cyc(h);
  endtask

  task automatic rstart_c();
    if (bus.scl && bus.sda) begin
      bus.sda = 1'b0;
    end else begin
      bus.scl = 1'b0; bus.sda = 1'b1; cyc(h);
      bus.scl = 1'b1; cyc(h);
      bus.sda = 1'b0;
    end
    cyc(h);
  endtask

  int s_vrise, s_vcyc, s_stop, s_ferr, s_ovr, s_both;
  task automatic snap();
    s_vrise = n_vrise; s_vcyc = n_vcyc; s_stop = n_stop;
    s_ferr = n_ferr; s_ovr = n_ovr; s_both = n_both;
    caps.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SIZE-1:0] rb;
    bit              ra;
    reset = 1'b1; bus.scl = 1'b1; bus.sda = 1'b1; bus.rx_ready = 1'b0;
    cyc(3);
    chk("reset_ack",   32'(bus.rx_ack),   32'd1);
    chk("reset_valid", 32'(bus.rx_valid), 32'd0);
    reset = 1'b0;
    cyc(3);

    // 0xA5, consumer ready.
    snap(); bus.rx_ready = 1'b1;
    start_c(); send_byte(8'hA5, 1'b0); stop_c(); cyc(10);
    chk("a5_model", 32'(e_data), 32'hA5);
    chk("a5_vrise", 32'(n_vrise - s_vrise), 32'd1);
    chk("a5_vcyc",  32'(n_vcyc - s_vcyc),   32'd1);
    chk("a5_data",  (caps.size() > 0) ? 32'(caps[0]) : 32'hDEAD, 32'hA5);
    chk("a5_ack",   32'(bus.rx_ack), 32'd0);
    chk("a5_stop",  32'(n_stop - s_stop), 32'd1);
    chk("a5_busy",  32'(bus.busy), 32'd0);

    // 0x3C then 0x81 with consumer stalled.
    snap(); bus.rx_ready = 1'b0;
    start_c(); send_byte(8'h3C, 1'b0); send_byte(8'h81, 1'b0); stop_c(); cyc(10);
    chk("ovr_data",  32'(bus.rx_data), 32'h3C);
    chk("ovr_valid", 32'(bus.rx_valid), 32'd1);
    chk("ovr_count", 32'(n_ovr - s_ovr), 32'd1);
    bus.rx_ready = 1'b1; cyc(1);
    chk("ovr_clear", 32'(bus.rx_valid), 32'd0);
    cyc(5);
    chk("ovr_nostale", 32'(n_vrise - s_vrise), 32'd1);
    chk("ovr_keep",    32'(bus.rx_data), 32'h3C);

    // STOP after four bits of 0xFF.
    snap();
    start_c(); for (int i = 0; i < 4; i++) send_bit(1'b1); stop_c(); cyc(10);
    chk("fe_both",  32'(n_both - s_both), 32'd1);
    chk("fe_ferr",  32'(n_ferr - s_ferr), 32'd1);
    chk("fe_valid", 32'(n_vrise - s_vrise), 32'd0);
    chk("fe_busy",  32'(bus.busy), 32'd0);

    // Reset after five bits, then 0x5A.
    snap();
    start_c(); for (int i = 0; i < 5; i++) send_bit(1'b1);
    reset = 1'b1; bus.scl = 1'b1; bus.sda = 1'b1; cyc(3);
    chk("rst_data",  32'(bus.rx_data),  32'd0);
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_ack",   32'(bus.rx_ack),   32'd1);
    reset = 1'b0; cyc(3);
    start_c(); send_byte(8'h5A, 1'b0); stop_c(); cyc(10);
    chk("rst_5a",   (caps.size() > 0) ? 32'(caps[caps.size()-1]) : 32'hDEAD, 32'h5A);
    chk("rst_ferr", 32'(n_ferr - s_ferr), 32'd0);
    chk("rst_ovr",  32'(n_ovr - s_ovr),   32'd0);
    chk("rst_stop", 32'(n_stop - s_stop), 32'd1);

    // SDA glitches with SCL low, then 0x01.
    snap();
    bus.scl = 1'b0; cyc(h);
    for (int i = 0; i < 3; i++) begin bus.sda = ~bus.sda; cyc(h); end
    bus.sda = 1'b1; cyc(h); bus.scl = 1'b1; cyc(h);
    chk("gl_quiet", 32'(n_stop - s_stop + n_ferr - s_ferr), 32'd0);
    chk("gl_busy",  32'(bus.busy), 32'd0);
    start_c(); send_byte(8'h01, 1'b0); stop_c(); cyc(10);
    chk("gl_data", 32'(bus.rx_data), 32'h01);
    chk("gl_ferr", 32'(n_ferr - s_ferr), 32'd0);

    // Repeated START between 0x12 and 0x34.
    snap();
    start_c(); send_byte(8'h12, 1'b1); rstart_c(); send_byte(8'h34, 1'b0); stop_c(); cyc(10);
    chk("rs_count", 32'(n_vrise - s_vrise), 32'd2);
    chk("rs_first", (caps.size() > 0) ? 32'(caps[0]) : 32'hDEAD, 32'h12);
    chk("rs_second", (caps.size() > 1) ? 32'(caps[1]) : 32'hDEAD, 32'h34);
    chk("rs_ferr",  32'(n_ferr - s_ferr), 32'd0);
    chk("rs_stop",  32'(n_stop - s_stop), 32'd1);

    // Randomised traffic against the model.
    rr_en = 1'b1;
    for (int n = 0; n < 24; n++) begin
      h = int'($urandom_range(2, 5));
      if (!bus.busy && bus.scl && bus.sda) start_c();
      rb = SIZE'($urandom);
      ra = 1'($urandom_range(0, 1));
      send_byte(rb, ra);
      case ($urandom_range(0, 3))
        0: stop_c();
        1: rstart_c();
        default: ;
      endcase
    end
    stop_c();
    rr_en = 1'b0; bus.rx_ready = 1'b1;
    cyc(12);
    chk("end_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
